// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one RAM port among NREQ requesters.
// Each access takes a GRANT cycle (RAM port driven) then a RESP cycle (read data / write ack).
module ram_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 6,
  parameter int DW   = 8,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we_in,
  input  logic [NREQ*AW-1:0] addr_in,
  input  logic [NREQ*DW-1:0] wdata_in,
  output logic [NREQ-1:0]    gnt,
  output logic               ram_we,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_data,
  input  logic [DW-1:0]      ram_q,
  output logic [DW-1:0]      rd_data,
  output logic               rd_valid,
  output logic               wr_done,
  output logic [IW-1:0]      resp_id,
  output logic [1:0]         dbg_state
);

  // Handshake: a requester holds req/we_in/addr_in/wdata_in stable until its
  // one-cycle gnt pulse; requests are sampled only in IDLE and RESP, and the
  // winner's fields are latched at that edge, so later input changes are ignored.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   cur_id;
  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic            found;
  logic [IW-1:0]   win;
  logic            take;

  // First set req bit at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          take    = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: state_d = RESP;
      RESP: begin
        if (found) begin
          take    = 1'b1;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr       <= '0;
      cur_id    <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rd_data   <= '0;
      resp_id   <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        cur_id    <= win;
        lat_we    <= we_in[win];
        lat_addr  <= addr_in[win*AW +: AW];
        lat_wdata <= wdata_in[win*DW +: DW];
      end
      if (state_q == GRANT) begin
        ptr     <= (cur_id == IW'(NREQ - 1)) ? '0 : cur_id + IW'(1);
        resp_id <= cur_id;
        if (!lat_we) rd_data <= ram_q;
      end
    end
  end

  // Latched fields only change on the edge into GRANT, so the port holds otherwise.
  assign ram_addr  = lat_addr;
  assign ram_data  = lat_wdata;
  assign ram_we    = (state_q == GRANT) && lat_we;
  assign rd_valid  = (state_q == RESP) && !lat_we;
  assign wr_done   = (state_q == RESP) && lat_we;
  assign dbg_state = state_q;

  always_comb begin
    gnt = '0;
    if (state_q == GRANT) gnt[cur_id] = 1'b1;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 64x8 RAM behind the port.
module tb_ram_port_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 6;
  localparam int DW   = 8;
  localparam int IW   = 2;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we_in;
  logic [NREQ*AW-1:0] addr_in;
  logic [NREQ*DW-1:0] wdata_in;
  logic [NREQ-1:0]    gnt;
  logic               ram_we;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_data;
  logic [DW-1:0]      ram_q;
  logic [DW-1:0]      rd_data;
  logic               rd_valid;
  logic               wr_done;
  logic [IW-1:0]      resp_id;
  logic [1:0]         dbg_state;

  logic [DW-1:0] mem [64];
  int n_checks = 0;
  int n_fail   = 0;

  ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .we_in(we_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .gnt(gnt), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_q(ram_q), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_done(wr_done), .resp_id(resp_id), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural RAM
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_data;
  assign ram_q = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // invariants every cycle
  always @(negedge clk) begin
    if (!rst) begin
      check("resp_exclusive", 32'(rd_valid && wr_done), 32'd0);
      check("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[id]              = 1'b1;
    we_in[id]            = w;
    addr_in[id*AW +: AW] = a;
    wdata_in[id*DW +: DW] = d;
  endtask

  initial begin
    rst = 1'b1; req = '0; we_in = '0; addr_in = '0; wdata_in = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_done", wr_done, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;

    // single write then read
    set_req(1, 1'b1, 6'd5, 8'hA5);
    step();
    check("t1_w_gnt", gnt, 4'b0010);
    check("t1_w_ram_we", ram_we, 1);
    check("t1_w_addr", ram_addr, 5);
    check("t1_w_data", ram_data, 8'hA5);
    req[1] = 1'b0;
    step();
    check("t1_w_done", wr_done, 1);
    check("t1_w_rdv", rd_valid, 0);
    check("t1_w_id", resp_id, 1);
    check("t1_w_we_off", ram_we, 0);
    check("t1_mem5", mem[5], 8'hA5);
    step();
    check("t1_idle", dbg_state, 0);
    set_req(1, 1'b0, 6'd5, 8'h00);
    step();
    check("t1_r_gnt", gnt, 4'b0010);
    check("t1_r_ram_we", ram_we, 0);
    req[1] = 1'b0;
    step();
    check("t1_r_valid", rd_valid, 1);
    check("t1_r_data", rd_data, 8'hA5);
    check("t1_r_id", resp_id, 1);
    step();

    // simultaneous reads right after a reset
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem[10+i] = 8'(8'h10 + 8'h11 * i);
      set_req(i, 1'b0, 6'(10 + i), 8'h00);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      check("t2_gnt", gnt, 32'(1 << k));
      req[k] = 1'b0;
      step();
      check("t2_valid", rd_valid, 1);
      check("t2_data", rd_data, 32'(8'h10 + 8'h11 * k));
      check("t2_id", resp_id, 32'(k));
    end
    step();

    // fairness: after serving 2, requester 3 beats 0
    set_req(2, 1'b1, 6'd20, 8'h5C);
    step();
    check("t3_gnt2", gnt, 4'b0100);
    req[2] = 1'b0;
    step();
    check("t3_done2", wr_done, 1);
    check("t3_id2", resp_id, 2);
    set_req(0, 1'b0, 6'd10, 8'h00);
    set_req(3, 1'b0, 6'd13, 8'h00);
    step();
    check("t3_gnt3_first", gnt, 4'b1000);
    req[3] = 1'b0;
    step();
    check("t3_data3", rd_data, 8'h43);
    check("t3_id3", resp_id, 3);
    step();
    check("t3_gnt0", gnt, 4'b0001);
    req[0] = 1'b0;
    step();
    check("t3_data0", rd_data, 8'h10);
    check("t3_id0", resp_id, 0);
    step();

    // back-to-back writes from requester 0
    set_req(0, 1'b1, 6'd30, 8'h11);
    step();
    check("t4_we1", ram_we, 1);
    check("t4_gnt1", gnt, 4'b0001);
    check("t4_addr1", ram_addr, 30);
    set_req(0, 1'b1, 6'd31, 8'h22);
    step();
    check("t4_we_gap", ram_we, 0);
    check("t4_done1", wr_done, 1);
    check("t4_id1", resp_id, 0);
    step();
    check("t4_we2", ram_we, 1);
    check("t4_addr2", ram_addr, 31);
    check("t4_data2", ram_data, 8'h22);
    req[0] = 1'b0;
    step();
    check("t4_we2_off", ram_we, 0);
    check("t4_done2", wr_done, 1);
    check("t4_mem30", mem[30], 8'h11);
    check("t4_mem31", mem[31], 8'h22);
    step();

    // req[3] pulsed only while requester 0 is in GRANT
    set_req(0, 1'b0, 6'd31, 8'h00);
    step();
    check("t5_gnt0", gnt, 4'b0001);
    req[0] = 1'b0;
    set_req(3, 1'b1, 6'd50, 8'hFF);
    step();
    req[3] = 1'b0;
    check("t5_valid", rd_valid, 1);
    check("t5_data", rd_data, 8'h22);
    step();
    check("t5_idle", dbg_state, 0);
    check("t5_no_gnt_a", gnt, 0);
    step();
    check("t5_no_gnt_b", gnt, 0);
    check("t5_no_we", ram_we, 0);
    check("t5_mem50", mem[50], 0);

    // reset during a write's GRANT, two requesters left pending
    set_req(0, 1'b0, 6'd30, 8'h00);
    set_req(1, 1'b1, 6'd40, 8'h77);
    step();
    check("t6_gnt1", gnt, 4'b0010);
    check("t6_we", ram_we, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_we", ram_we, 0);
    check("t6_rst_gnt", gnt, 0);
    check("t6_rst_addr", ram_addr, 0);
    check("t6_rst_done", wr_done, 0);
    check("t6_rst_state", dbg_state, 0);
    #2;
    rst = 1'b0;
    step();
    check("t6_ptr0_gnt", gnt, 4'b0001);
    check("t6_mem40_untouched", mem[40], 0);
    req[0] = 1'b0;
    step();
    check("t6_r_valid", rd_valid, 1);
    check("t6_r_data", rd_data, 8'h11);
    check("t6_r_id", resp_id, 0);
    step();
    check("t6_gnt1_again", gnt, 4'b0010);
    check("t6_we_again", ram_we, 1);
    req[1] = 1'b0;
    step();
    check("t6_done", wr_done, 1);
    check("t6_done_id", resp_id, 1);
    check("t6_mem40", mem[40], 8'h77);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter and sequencer that shares one port of the 64x8 dual-port RAM between NREQ requesters. Each requester issues a read or write with a req/gnt handshake. The arbiter latches the winning request and drives the RAM port signals from registers, with `ram_we` asserted for exactly one cycle. Read data is captured and returned with a valid strobe and the requester ID. One instance sits in front of each RAM port.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 6, RAM address width
- DW, 8, RAM data width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  request per requester; held until granted
- we_in  in  NREQ  1 = write, 0 = read, per requester
- addr_in  in  NREQ*AW  packed addresses, requester i at bits [i*AW +: AW]
- wdata_in  in  NREQ*DW  packed write data, requester i at bits [i*DW +: DW]
- gnt  out  NREQ  one-hot grant pulse, one cycle
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_data  out  DW  RAM write data
- ram_q  in  DW  RAM read data (combinational from RAM)
- rd_data  out  DW  captured read data
- rd_valid  out  1  rd_data valid, one-cycle pulse
- wr_done  out  1  write completed, one-cycle pulse
- resp_id  out  $clog2(NREQ)  requester index for rd_valid/wr_done

## Operation
- FSM has three states: IDLE, GRANT, RESP.
- IDLE: if any req bit is set, pick a winner round-robin, latch its we/addr/wdata into registers and its index into cur_id, then go to GRANT. Otherwise stay in IDLE.
- GRANT (exactly 1 cycle):
  - gnt[cur_id]=1.
  - ram_addr and ram_data come from the latched registers.
  - ram_we = latched we.
  - At the end of the cycle, capture ram_q into rd_data if the access is a read.
  - Update ptr = cur_id+1 (mod NREQ).
  - Go to RESP.
- RESP (exactly 1 cycle):
  - rd_valid=1 for a read, or wr_done=1 for a write.
  - resp_id=cur_id.
  - Arbitrate exactly as in IDLE: with a pending req, latch the winner and go to GRANT; otherwise go to IDLE.
- Round-robin rule: search starts at index ptr, ascending with wrap-around; the first set req bit wins. ptr resets to 0.
- A requester keeps req, we_in, addr_in and wdata_in stable until it sees its gnt bit. It deasserts req on the edge after its gnt cycle, unless it is issuing a new request.
- A req withdrawn before arbitration samples it is never granted and causes no access.
- Requests are sampled only in IDLE/RESP. Input changes after the latch have no effect on the access in flight.
- ram_addr and ram_data hold their last values outside GRANT. ram_we=0 outside GRANT.
- rd_data holds its value until the next read capture. resp_id holds until the next response.

## Timing
- Reset values: state=IDLE, ptr=0, gnt=0, ram_we=0, ram_addr=0, ram_data=0, rd_data=0, rd_valid=0, wr_done=0, resp_id=0.
- Latency:
  - req first seen high in IDLE at cycle N: gnt and RAM access in N+1, rd_valid/wr_done in N+2.
  - Minimum request-to-response latency is 2 cycles.
- Throughput: one access every 2 cycles under continuous requests (GRANT, RESP, GRANT, ...).
- Exactly one gnt bit per GRANT cycle. Never more than one response pulse per cycle. rd_valid and wr_done are never both high.
- Simultaneous requests: served in round-robin order from ptr. No requester waits more than NREQ-1 other grants.
- Reset mid-operation: rst forces ram_we=0 and all outputs to reset values immediately, without waiting for clk. A write interrupted in GRANT leaves the target RAM word undefined. No response pulse is produced for an aborted access.
- After rst deasserts, the first arbitration happens in the first clk edge's IDLE cycle, with ptr=0.

## Test plan
- Single write then read:
  - Stimulus: req[1] write addr=5 wdata=0xA5; after wr_done, req[1] read addr=5.
  - Required response: gnt=0010 one cycle after req; wr_done with resp_id=1 two cycles after req; then rd_valid with rd_data=0xA5, resp_id=1.
- Simultaneous requests:
  - Stimulus: all four req set in the same cycle after reset, each reading a distinct preloaded address.
  - Required response: grants in order 0,1,2,3 on every other cycle; four rd_valid pulses with matching resp_id and data.
- Fairness with ptr:
  - Stimulus: req[2] served first, then req[0] and req[3] requested together.
  - Required response: req[3] is granted before req[0].
- Back-to-back:
  - Stimulus: req[0] re-asserts a write in its RESP cycle.
  - Required response: next GRANT follows immediately; ram_we pulses are 2 cycles apart and each exactly 1 cycle wide.
- Withdrawn request:
  - Stimulus: req[3] pulses for one cycle while the FSM is in GRANT for requester 0.
  - Required response: no gnt[3] and no access for requester 3.
- Reset mid-GRANT:
  - Stimulus: assert rst during a write's GRANT cycle, between clock edges.
  - Required response: ram_we and gnt drop immediately; no wr_done; after release, req[1] pending is granted with ptr=0 semantics.
